// File: rtl/stat_resp_misr_pkg.sv
// Shared types and constants for the Stat benchmark response compactor.
package stat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stat_misr_state_e;

    localparam int          STAT_RESP_W            = 24;
    localparam logic [23:0] STAT_MISR_POLY_DEFAULT = 24'hC20001;

endpackage

// File: rtl/stat_resp_misr_step.sv
// One Galois MISR step: shift left, fold the outgoing MSB through POLY, xor in the response.
module stat_misr_step
    import stat_pkg::*;
#(
    parameter int               WIDTH = STAT_RESP_W,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(STAT_MISR_POLY_DEFAULT)
) (
    input  logic [WIDTH-1:0] sig_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    genvar gi;

    assign sig_o[0] = (sig_i[WIDTH-1] & POLY[0]) ^ data_i[0];

    for (gi = 1; gi < WIDTH; gi++) begin : g_bit
        assign sig_o[gi] = sig_i[gi-1] ^ (sig_i[WIDTH-1] & POLY[gi]) ^ data_i[gi];
    end

endmodule

// File: rtl/stat_resp_misr.sv
// Response compactor: folds PATTERN_COUNT responses into a MISR signature, then holds it.
// Optional golden compare is enabled by defining STAT_MISR_GOLDEN_CMP_EN.
module stat_resp_misr
    import stat_pkg::*;
#(
    parameter int               WIDTH         = STAT_RESP_W,
    parameter logic [WIDTH-1:0] POLY          = WIDTH'(STAT_MISR_POLY_DEFAULT),
    parameter logic [WIDTH-1:0] SEED          = '0,
    parameter int               PATTERN_COUNT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
`ifdef STAT_MISR_GOLDEN_CMP_EN
    input  logic [WIDTH-1:0] golden,
    output logic             pass,
`endif
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      pat_count
);

    localparam logic [15:0] LAST_CNT = 16'(PATTERN_COUNT - 1);

    stat_misr_state_e state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d, sig_step;
    logic [15:0]      cnt_q, cnt_d;
    logic             accept;

    stat_misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .sig_i  (sig_q),
        .data_i (resp_data),
        .sig_o  (sig_step)
    );

    assign accept = (state_q == RUN) && resp_valid;

`ifdef STAT_MISR_GOLDEN_CMP_EN
    logic pass_q, pass_d;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
`ifdef STAT_MISR_GOLDEN_CMP_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            RUN: begin
                if (accept) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
`ifdef STAT_MISR_GOLDEN_CMP_EN
                        pass_d  = (sig_step == golden);
`endif
                    end
                end
            end
            default: begin
                // IDLE and DONE both reseed on start; start during RUN is ignored
                if (start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
`ifdef STAT_MISR_GOLDEN_CMP_EN
                    pass_d  = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
`ifdef STAT_MISR_GOLDEN_CMP_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
`ifdef STAT_MISR_GOLDEN_CMP_EN
            pass_q  <= pass_d;
`endif
        end
    end

    assign resp_ready = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign signature  = sig_q;
    assign pat_count  = cnt_q;
`ifdef STAT_MISR_GOLDEN_CMP_EN
    assign pass       = pass_q;
`endif

endmodule

// File: tb/tb_stat_resp_misr.sv
// Scoreboard bench: a 4-bit and a 24-bit compactor share stimulus; a polynomial model predicts results.
`timescale 1ns/1ps
module tb_stat_resp_misr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic        resp_valid = 1'b0;
    logic [23:0] resp_data  = '0;
    logic [3:0]  golden_s   = '0;
    logic [23:0] golden_b   = '0;

    logic        rdy_s, busy_s, done_s;
    logic [3:0]  sig_s;
    logic [15:0] cnt_s;
    logic        rdy_b, busy_b, done_b;
    logic [23:0] sig_b;
    logic [15:0] cnt_b;
`ifdef STAT_MISR_GOLDEN_CMP_EN
    logic        pass_s, pass_b;
`endif

    stat_resp_misr #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .PATTERN_COUNT(3)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .resp_valid (resp_valid),
        .resp_data  (resp_data[3:0]),
`ifdef STAT_MISR_GOLDEN_CMP_EN
        .golden     (golden_s),
        .pass       (pass_s),
`endif
        .resp_ready (rdy_s),
        .busy       (busy_s),
        .done       (done_s),
        .signature  (sig_s),
        .pat_count  (cnt_s)
    );

    stat_resp_misr #(.WIDTH(24), .POLY(24'hC20001), .SEED(24'h0), .PATTERN_COUNT(3)) u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
`ifdef STAT_MISR_GOLDEN_CMP_EN
        .golden     (golden_b),
        .pass       (pass_b),
`endif
        .resp_ready (rdy_b),
        .busy       (busy_b),
        .done       (done_b),
        .signature  (sig_b),
        .pat_count  (cnt_b)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  s;
        logic [23:0] b;
        int          cnt;
        bit          pass;
    } exp_t;

    exp_t acc_q[$];
    exp_t done_q[$];

    // Model: 0 idle, 1 running, 2 done; values describe the state after the coming edge
    int          mstate = 0;
    logic [3:0]  m_s    = '0;
    logic [23:0] m_b    = '0;
    int          mcnt   = 0;

    // Multiply by x modulo (x^w + poly), then add the response
    function automatic logic [23:0] ref_step(int w, logic [23:0] poly, logic [23:0] s, logic [23:0] d);
        longint unsigned t, p, mask;
        t    = longint'(s) << 1;
        p    = (64'd1 << w) | longint'(poly);
        mask = (64'd1 << w) - 64'd1;
        if (t[w]) t = t ^ p;
        return 24'((t ^ longint'(d)) & mask);
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus driven at the falling edge, with the model advanced to match
    task automatic step(input bit st, input bit v, input logic [23:0] d, input bit rl, input logic [3:0] g);
        exp_t e;
        @(negedge clk);
        start      = st;
        resp_valid = v;
        resp_data  = d;
        rst_n      = !rl;
        golden_s   = g;
        if (rl) begin
            mstate = 0; m_s = '0; m_b = '0; mcnt = 0;
        end else if (mstate == 1) begin
            if (v) begin
                m_s  = 4'(ref_step(4, 24'h3, {20'd0, m_s}, {20'd0, d[3:0]}));
                m_b  = ref_step(24, 24'hC20001, m_b, d);
                mcnt = mcnt + 1;
                e.s = m_s; e.b = m_b; e.cnt = mcnt; e.pass = (m_s == g);
                acc_q.push_back(e);
                if (mcnt == 3) begin
                    mstate = 2;
                    done_q.push_back(e);
                end
            end
        end else if (st) begin
            mstate = 1; m_s = '0; m_b = '0; mcnt = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 24'h0, 0, golden_s);
    endtask

    // Monitor: compares whenever a DUT presents an accept or a completion
    logic rdy_last  = 1'b0;
    logic done_last = 1'b0;
    exp_t me;
    int   acc_n = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n && resp_valid && rdy_last) begin
            acc_n++;
            if (acc_q.size() == 0) begin
                total++; bad++;
                $display("FAIL accept: got unexpected accept %0d expected none", acc_n);
            end else begin
                me = acc_q.pop_front();
                $display("accept %0d: data=%h sig_s=%h sig_b=%h cnt=%0d", acc_n, resp_data, sig_s, sig_b, cnt_s);
                chk("sig_small", sig_s, me.s);
                chk("sig_big", sig_b, me.b);
                chk("pat_count", cnt_s, me.cnt);
            end
        end
        if (done_s && !done_last) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL done_rise: got unexpected done expected none");
            end else begin
                me = done_q.pop_front();
                chk("done_sig", sig_s, me.s);
                chk("done_cnt", cnt_s, me.cnt);
`ifdef STAT_MISR_GOLDEN_CMP_EN
                chk("pass", pass_s, me.pass);
`endif
            end
        end
        chk("state_flags", {rdy_s, busy_s, done_s, rdy_b, busy_b, done_b},
            {3{(mstate == 1), (mstate == 1), (mstate == 2)}} & 6'b111111
            & {(mstate == 1), (mstate == 1), (mstate == 2), (mstate == 1), (mstate == 1), (mstate == 2)});
        rdy_last  = rdy_s;
        done_last = done_s;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        for (int i = 0; i < 3; i++) step(0, 0, 24'h0, 1, 4'h0);
        idle(2);
        chk("reset_sig", sig_s, 0);
        chk("reset_cnt", cnt_s, 0);

        // Back-to-back run: 1, 8, 1 -> 1, A, 6
        step(1, 0, 24'h0, 0, 4'h6);
        step(0, 1, 24'h123451, 0, 4'h6);
        step(0, 1, 24'hABCDE8, 0, 4'h6);
        step(0, 1, 24'h000001, 0, 4'h6);
        idle(2);
        chk("run1_final", sig_s, 4'h6);

        // Gap after the second response; golden mismatch this time
        step(1, 0, 24'h0, 0, 4'h7);
        step(0, 1, 24'h000001, 0, 4'h7);
        step(0, 1, 24'h000008, 0, 4'h7);
        idle(3);
        chk("gap_hold", sig_s, 4'hA);
        step(0, 1, 24'h000001, 0, 4'h7);
        idle(1);
        chk("run2_final", sig_s, 4'h6);

        // Reset after two accepts, then a clean rerun
        step(1, 0, 24'h0, 0, 4'h6);
        step(0, 1, 24'h000001, 0, 4'h6);
        step(0, 1, 24'h000008, 0, 4'h6);
        step(0, 1, 24'h000001, 1, 4'h6);
        idle(1);
        chk("midreset_sig", sig_s, 0);
        step(1, 1, 24'h00000F, 0, 4'h6);
        step(1, 1, 24'h000001, 0, 4'h6);
        step(0, 1, 24'h000008, 0, 4'h6);
        step(0, 1, 24'h000001, 0, 4'h6);

        // Valid while DONE is dropped; start reseeds
        for (int i = 0; i < 5; i++) step(0, 1, 24'hFFFFFF, 0, 4'h6);
        chk("done_hold", sig_s, 4'h6);
        step(1, 1, 24'h00000F, 0, 4'h6);
        idle(1);
        chk("restart_sig", sig_s, 0);
        chk("restart_cnt", cnt_s, 0);
        chk("restart_busy", busy_s, 1);

        // Randomized traffic with occasional starts and resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), 24'($urandom),
                 ($urandom_range(0, 79) == 0), 4'($urandom_range(0, 15)));
        end
        idle(3);
        chk("acc_queue_empty", acc_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stat_resp_misr.md
# stat_resp_misr

Sequential response compactor placed directly downstream of a combinational Stat benchmark netlist under test; the 24 benchmark outputs are its data input. The block accepts a fixed number of response vectors over a valid/ready handshake and folds them into a Galois MISR signature. It then reports completion and holds the signature for readout until the next start. It makes the combinational benchmark usable in a clocked self-test harness.

## Interface
- WIDTH, 24: response and signature width; equals the benchmark output count.
- POLY, 24'hC20001: Galois feedback mask, bit i set when the x^i term is present; x^WIDTH is implied.
- SEED, 0: signature value loaded on reset and on start.
- PATTERN_COUNT, 256: responses folded per run; legal range 1 to 65535.
- clk  in  1  sole clock; everything is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run; honoured in IDLE and DONE, ignored in RUN.
- resp_valid  in  1  resp_data is valid this cycle.
- resp_data  in  WIDTH  benchmark outputs, bit 0 = first output in port order.
- resp_ready  out  1  block accepts a response this cycle.
- busy  out  1  state is RUN.
- done  out  1  run complete, signature final.
- signature  out  WIDTH  current MISR contents.
- pat_count  out  16  responses accepted in the current run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start -> RUN; sig <= SEED; pat_count <= 0.
- RUN: resp_ready = 1. A response is accepted in any cycle with resp_valid && resp_ready.
- On accept: sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ resp_data; pat_count <= pat_count + 1.
- The accept that makes pat_count reach PATTERN_COUNT also moves the state to DONE in the same edge.
- DONE: resp_ready = 0; signature and pat_count hold; done = 1. start -> RUN with a reseed; without start, DONE persists.
- Any resp_valid outside RUN is dropped and has no side effects.
- pat_count never wraps, because the terminal count forces DONE.

## Timing
- Reset values: state IDLE, signature = SEED, pat_count = 0, resp_ready = 0, busy = 0, done = 0.
- Reset wins over start and over accept in the same cycle.
- A reset mid-run discards the partial signature.
- resp_ready and busy are registered-state decodes. They rise 1 cycle after start is sampled and fall in the cycle after the final accept.
- Throughput is 1 response per cycle. Latency from the final accept to done = 1 is 1 cycle, and signature is final in that same cycle.
- start coincident with resp_valid in IDLE or DONE: the response is dropped, because ready was 0.
- start and resp_valid in RUN: start is ignored and the response is accepted.

## Configuration
- STAT_MISR_GOLDEN_CMP_EN defined: adds input golden[WIDTH-1:0] and output pass[1].
  - pass is registered when entering DONE as (sig_next == golden) and holds until the next start or reset.
  - pass resets to 0.
- STAT_MISR_GOLDEN_CMP_EN undefined: neither port exists. Everything else is unchanged.

## Structure
- Shared package stat_pkg holds:
  - state enum stat_misr_state_e (IDLE, RUN, DONE);
  - STAT_RESP_W = 24;
  - STAT_MISR_POLY_DEFAULT = 24'hC20001.
- One sub-module, stat_misr_step: a purely combinational next-signature function parameterised by WIDTH and POLY, reusable by the test bench's reference model.
- The FSM, counter and registers live in stat_resp_misr.

## Test plan
- Reset then idle with WIDTH=4, POLY=4'h3, SEED=0. Expect resp_ready=0, done=0, signature=0, pat_count=0.
- Same parameters, PATTERN_COUNT=3. Pulse start, then feed 4'h1, 4'h8, 4'h1 back-to-back with valid held. Expect:
  - signature 1, then A, then 6;
  - done=1 one cycle after the third accept;
  - pat_count=3;
  - resp_ready=0.
- Same run with a valid gap after the second response. Expect the signature to hold at A during the gap and the final value 6 unchanged.
- Assert rst_n low after 2 of 3 accepts. Expect IDLE, signature=0, and a subsequent start/run yielding 6 again.
- In DONE, drive resp_valid with 4'hF for 5 cycles. Expect signature 6 to hold. Then start: signature=SEED, pat_count=0, busy=1 the next cycle.
- With STAT_MISR_GOLDEN_CMP_EN defined and golden=4'h6, run the sequence above. Expect pass=1. Repeat with golden=4'h7 and expect pass=0.
